cordic_hyp_sched: RTL and testbench
===================================

# cordic_hyp_sched

Request scheduler and result collector for the pipelined hyperbolic CORDIC unit (exp/ln). Sits between a ready/valid request source and the CORDIC's `start`/`func`/`a` inputs and `valid`/`f` outputs. Issues at most one operation per cycle and tags each in order. Retires results into an in-order entry buffer and presents them on a ready/valid response port. Admission is credit-controlled, so a result never arrives without a free slot.

## Interface

Parameters:
- `W`, 12 — CORDIC width; data buses are `2*W` bits.
- `AW`, 4 — buffer address width; `DEPTH = 2**AW` entries.
- `TAG_W`, 4 — request tag width.

Ports:
- `clk` in 1 — single clock; all logic on rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low; shared with the CORDIC instance.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — request can be accepted.
- `req_func` in 1 — 0 = exp, 1 = ln.
- `req_a` in `2*W` — operand.
- `req_tag` in `TAG_W` — caller tag, returned with result.
- `start` out 1 — to CORDIC `start`.
- `func` out 1 — to CORDIC `func`.
- `a` out `2*W` — to CORDIC `a`.
- `valid` in 1 — from CORDIC `valid`.
- `f` in `2*W` — from CORDIC `f`.
- `rsp_valid` out 1 — response available.
- `rsp_ready` in 1 — response consumed.
- `rsp_f` out `2*W` — result.
- `rsp_func` out 1 — function of this result.
- `rsp_tag` out `TAG_W` — tag of this result.
- `busy` out 1 — any entry allocated.
- `err_unexp` out 1 — sticky: CORDIC `valid` seen with no outstanding operation.

## Operation

- Buffer: `DEPTH` entries of {tag, func, f}. Three `AW+1`-bit pointers:
  - `wp` — allocate.
  - `fp` — fill.
  - `rp` — retire.
  - Invariant: `rp <= fp <= wp` modulo wrap; the MSB disambiguates full from empty.
- Accept: `req_valid & req_ready` at an edge.
  - Writes tag/func at `wp` and increments `wp`.
  - Next cycle: `start`=1 for exactly one cycle, with `func`/`a` registered from the request.
  - `start`=0 in any cycle with no accept. `func`/`a` hold their last value when idle.
- Fill: `valid`=1 at an edge with `fp != wp` writes `f` at `fp` and increments `fp`. CORDIC results return in issue order, so no tag match is needed.
- Unexpected: `valid`=1 with `fp == wp` sets `err_unexp`.
  - Data is discarded; pointers are unchanged.
  - `err_unexp` clears only on reset.
- Retire: `rsp_valid & rsp_ready` increments `rp`.
- Response outputs:
  - `rsp_valid` = (`fp != rp`).
  - `rsp_f`/`rsp_func`/`rsp_tag` read the entry at `rp`.
  - Values are stable while `rsp_valid & !rsp_ready`.
- `req_ready` = (`wp - rp < DEPTH`). It is a function of registered pointers only; no combinational path from `req_valid` or `rsp_ready`.
- `busy` = (`wp != rp`).
- Accept, fill and retire may all occur in the same cycle; each pointer updates independently.
  - A full buffer plus a same-cycle retire still refuses the request that cycle (no pass-through).
  - A fill and a retire of the same entry cannot coincide, because retire requires `fp != rp` before the edge.
- Pointer wrap: natural modulo `2**(AW+1)`; behaviour is identical across wrap.

## Timing

- Reset values:
  - `start`=0, `func`=0, `a`=0.
  - `rsp_valid`=0, `rsp_f`/`rsp_func`/`rsp_tag`=0 (buffer cleared).
  - `req_ready`=1, `busy`=0, `err_unexp`=0.
  - All pointers = 0.
- Accept at edge N:
  - `start` high during cycle N+1.
  - The CORDIC returns `valid` at edge N+1+`W`+3.
  - `rsp_valid` is high from the following cycle.
  - Request-to-response latency: `W`+5 cycles (17 at `W`=12).
- Throughput: one accept, one fill and one retire per cycle, sustained.
- Reset mid-operation: all entries dropped and outputs return to reset values immediately (async). The CORDIC is reset by the same `rst_n`, so no stale `valid` follows.

## Test plan

Test plan — CORDIC replaced by a model: delay line of `W`+3 from `start` to `valid`, `f` = `a` ^ 24'hA5A5A5.
- Single request: func=1, a=24'h000800, tag=3, accepted at edge N.
  - Expect `start` pulse in cycle N+1 and `rsp_valid` from cycle N+17.
  - Expect `rsp_f`=24'hA5ADA5, `rsp_func`=1, `rsp_tag`=3.
  - `busy` falls after retire.
- Fill: `rsp_ready`=0, `req_valid`=1 continuously, tags 0..19.
  - Exactly 16 accepts, then `req_ready`=0.
  - `start` pulses exactly 16 times.
  - Release `rsp_ready`: tags 0..15 in order, one per cycle. `req_ready` reasserts the cycle after the first retire.
- Streaming: 40 back-to-back requests with `rsp_ready`=1.
  - 40 consecutive `start` cycles and 40 consecutive `rsp_valid` cycles.
  - Tags in order across pointer wrap.
- Random `rsp_ready` at 30% and random `req_valid`: scoreboard order and data match, no loss or duplication, `err_unexp` stays 0.
- Inject `valid`=1 from the testbench with an empty buffer: `err_unexp`=1 permanently, `rsp_valid` stays 0.
- Assert `rst_n`=0 with 5 results outstanding and 3 buffered: same cycle `rsp_valid`=0, `busy`=0, `start`=0. After release, a new request completes normally with latency 17.

Source files
------------

// File: rtl/cordic_hyp_sched.sv
// Request scheduler and in-order result collector for the pipelined hyperbolic
// CORDIC unit. Credit-based admission guarantees every returning result has a slot.
module cordic_hyp_sched #(
  parameter int W     = 12,
  parameter int AW    = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_func,
  input  logic [2*W-1:0]   req_a,
  input  logic [TAG_W-1:0] req_tag,
  output logic             start,
  output logic             func,
  output logic [2*W-1:0]   a,
  input  logic             valid,
  input  logic [2*W-1:0]   f,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*W-1:0]   rsp_f,
  output logic             rsp_func,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic             err_unexp
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [AW:0]        wp_q, wp_d;
  logic [AW:0]        fp_q, fp_d;
  logic [AW:0]        rp_q, rp_d;
  logic [AW:0]        occ;
  logic               start_q;
  logic               func_q;
  logic [2*W-1:0]     a_q;
  logic               err_q, err_d;
  logic               accept, fill, retire, unexp;

  logic [TAG_W-1:0]   tag_mem_q  [DEPTH];
  logic               func_mem_q [DEPTH];
  logic [2*W-1:0]     f_mem_q    [DEPTH];

  // Occupancy MSB set means wp has lapped rp by a full DEPTH: no credit left.
  always_comb begin
    occ       = wp_q - rp_q;
    req_ready = ~occ[AW];
    rsp_valid = (fp_q != rp_q);
    busy      = (wp_q != rp_q);
    accept    = req_valid & req_ready;
    fill      = valid & (fp_q != wp_q);
    unexp     = valid & (fp_q == wp_q);
    retire    = rsp_valid & rsp_ready;
    wp_d      = wp_q + {{AW{1'b0}}, accept};
    fp_d      = fp_q + {{AW{1'b0}}, fill};
    rp_d      = rp_q + {{AW{1'b0}}, retire};
    err_d     = err_q | unexp;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      fp_q    <= '0;
      rp_q    <= '0;
      start_q <= 1'b0;
      func_q  <= 1'b0;
      a_q     <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_mem_q[i]  <= '0;
        func_mem_q[i] <= 1'b0;
        f_mem_q[i]    <= '0;
      end
    end else begin
      wp_q    <= wp_d;
      fp_q    <= fp_d;
      rp_q    <= rp_d;
      err_q   <= err_d;
      start_q <= accept;
      if (accept) begin
        func_q                    <= req_func;
        a_q                       <= req_a;
        tag_mem_q[wp_q[AW-1:0]]   <= req_tag;
        func_mem_q[wp_q[AW-1:0]]  <= req_func;
      end
      if (fill) begin
        f_mem_q[fp_q[AW-1:0]] <= f;
      end
    end
  end

  always_comb begin
    start     = start_q;
    func      = func_q;
    a         = a_q;
    err_unexp = err_q;
    rsp_f     = f_mem_q[rp_q[AW-1:0]];
    rsp_func  = func_mem_q[rp_q[AW-1:0]];
    rsp_tag   = tag_mem_q[rp_q[AW-1:0]];
  end

endmodule

// File: tb/tb_cordic_hyp_sched.sv
// Directed bench for cordic_hyp_sched with a delay-line CORDIC stand-in
// (valid W+3 cycles after start, f = a ^ 24'hA5A5A5).
module tb_cordic_hyp_sched;

  localparam int W     = 12;
  localparam int AW    = 4;
  localparam int TAG_W = 4;

  logic             clk;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic             req_func;
  logic [2*W-1:0]   req_a;
  logic [TAG_W-1:0] req_tag;
  logic             start;
  logic             func;
  logic [2*W-1:0]   a;
  logic             valid;
  logic [2*W-1:0]   f;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2*W-1:0]   rsp_f;
  logic             rsp_func;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;
  logic             err_unexp;

  logic             inj;
  logic [W+2:0]     vsr;
  logic [2*W-1:0]   fsr [W+3];

  int total = 0;
  int bad   = 0;
  int nacc, nstart, nret, lat, guard;

  logic [TAG_W-1:0] sb_tag  [$];
  logic             sb_func [$];
  logic [2*W-1:0]   sb_f    [$];

  cordic_hyp_sched #(.W(W), .AW(AW), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_func  (req_func),
    .req_a     (req_a),
    .req_tag   (req_tag),
    .start     (start),
    .func      (func),
    .a         (a),
    .valid     (valid),
    .f         (f),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_f     (rsp_f),
    .rsp_func  (rsp_func),
    .rsp_tag   (rsp_tag),
    .busy      (busy),
    .err_unexp (err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // CORDIC stand-in, reset by the same rst_n
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsr <= '0;
      for (int i = 0; i < W + 3; i++) fsr[i] <= '0;
    end else begin
      vsr    <= {vsr[W+1:0], start};
      fsr[0] <= a ^ 24'hA5A5A5;
      for (int i = 1; i < W + 3; i++) fsr[i] <= fsr[i-1];
    end
  end

  assign valid = vsr[W+2] | inj;
  assign f     = fsr[W+2];

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bookkeeping for the edge about to happen, then advance one cycle.
  task automatic cyc();
    if (req_valid && req_ready) begin
      sb_tag.push_back(req_tag);
      sb_func.push_back(req_func);
      sb_f.push_back(req_a ^ 24'hA5A5A5);
      nacc++;
    end
    if (rsp_valid && rsp_ready) begin
      if (sb_tag.size() == 0) begin
        chk("rsp_extra", {31'd0, rsp_valid}, 32'd0);
      end else begin
        chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, sb_tag.pop_front()});
        chk("rsp_func", {31'd0, rsp_func}, {31'd0, sb_func.pop_front()});
        chk("rsp_f", {8'd0, rsp_f}, {8'd0, sb_f.pop_front()});
      end
      nret++;
    end
    if (start) nstart++;
    tick();
  endtask

  task automatic single_req(input string pfx);
    req_valid = 1'b1; req_func = 1'b1; req_a = 24'h000800; req_tag = 4'd3;
    chk({pfx, "_ready"}, {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk({pfx, "_start"}, {31'd0, start}, 32'd1);
    chk({pfx, "_func"}, {31'd0, func}, 32'd1);
    chk({pfx, "_a"}, {8'd0, a}, 32'h000800);
    tick();
    chk({pfx, "_start_pulse"}, {31'd0, start}, 32'd0);
    lat = 2;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({pfx, "_latency"}, lat, 32'd17);
    chk({pfx, "_rsp_f"}, {8'd0, rsp_f}, 32'hA5ADA5);
    chk({pfx, "_rsp_func"}, {31'd0, rsp_func}, 32'd1);
    chk({pfx, "_rsp_tag"}, {28'd0, rsp_tag}, 32'd3);
    chk({pfx, "_busy_held"}, {31'd0, busy}, 32'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({pfx, "_busy_done"}, {31'd0, busy}, 32'd0);
    chk({pfx, "_rsp_gone"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_func = 1'b0; req_a = '0; req_tag = '0;
    rsp_ready = 1'b0; inj = 1'b0;
    nacc = 0; nstart = 0; nret = 0;
    tick(); tick();

    // reset state
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_func", {31'd0, func}, 32'd0);
    chk("rst_a", {8'd0, a}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_f", {8'd0, rsp_f}, 32'd0);
    chk("rst_rsp_tag", {28'd0, rsp_tag}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_unexp}, 32'd0);
    rst_n = 1'b1;
    tick();

    single_req("t1");

    // fill with rsp_ready low
    nacc = 0; nstart = 0; nret = 0;
    req_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      req_tag  = nacc[TAG_W-1:0];
      req_a    = nacc[2*W-1:0];
      req_func = nacc[0];
      cyc();
    end
    chk("t2_accepts", nacc, 32'd16);
    chk("t2_starts", nstart, 32'd16);
    chk("t2_full_ready", {31'd0, req_ready}, 32'd0);
    chk("t2_first_tag", {28'd0, rsp_tag}, 32'd0);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    cyc();
    chk("t2_ready_back", {31'd0, req_ready}, 32'd1);
    for (int c = 0; c < 15; c++) cyc();
    rsp_ready = 1'b0;
    chk("t2_retired", nret, 32'd16);
    chk("t2_drained", {31'd0, rsp_valid}, 32'd0);
    chk("t2_idle", {31'd0, busy}, 32'd0);

    // streaming across pointer wrap
    nacc = 0; nstart = 0; nret = 0; guard = 0;
    rsp_ready = 1'b1;
    while (nret < 40 && guard < 300) begin
      req_valid = (nacc < 40);
      req_tag   = nacc[TAG_W-1:0];
      req_a     = {nacc[7:0], 16'h1234};
      req_func  = nacc[1];
      cyc();
      guard++;
    end
    req_valid = 1'b0;
    chk("t3_accepts", nacc, 32'd40);
    chk("t3_starts", nstart, 32'd40);
    chk("t3_retired", nret, 32'd40);
    chk("t3_busy", {31'd0, busy}, 32'd0);

    // random valid / 30% rsp_ready
    nacc = 0; nret = 0;
    for (int c = 0; c < 300; c++) begin
      req_valid = $urandom_range(0, 1) == 1;
      rsp_ready = $urandom_range(0, 9) < 3;
      req_tag   = TAG_W'($urandom);
      req_func  = 1'($urandom);
      req_a     = (2*W)'($urandom);
      cyc();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    guard = 0;
    while (busy && guard < 200) begin
      cyc();
      guard++;
    end
    rsp_ready = 1'b0;
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_count", nret, nacc);
    chk("t4_sb_left", sb_tag.size(), 32'd0);
    chk("t4_err", {31'd0, err_unexp}, 32'd0);

    // unexpected valid
    chk("t5_empty", {31'd0, busy}, 32'd0);
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("t5_err", {31'd0, err_unexp}, 32'd1);
    chk("t5_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    repeat (5) tick();
    chk("t5_err_sticky", {31'd0, err_unexp}, 32'd1);

    // async reset with 5 outstanding and 3 buffered
    nacc = 0; guard = 0;
    req_valid = 1'b1;
    while (nacc < 8 && guard < 20) begin
      req_tag  = nacc[TAG_W-1:0];
      req_a    = nacc[2*W-1:0];
      req_func = 1'b0;
      cyc();
      guard++;
    end
    req_valid = 1'b0;
    guard = 0;
    while (!rsp_valid && guard < 40) begin
      tick();
      guard++;
    end
    chk("t6_first_fill", {31'd0, rsp_valid}, 32'd1);
    tick(); tick();
    chk("t6_head_tag", {28'd0, rsp_tag}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t6_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_start", {31'd0, start}, 32'd0);
    chk("t6_err", {31'd0, err_unexp}, 32'd0);
    chk("t6_req_ready", {31'd0, req_ready}, 32'd1);
    sb_tag.delete(); sb_func.delete(); sb_f.delete();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    single_req("t6r");
    repeat (20) tick();
    chk("t6_no_stale", {31'd0, rsp_valid}, 32'd0);
    chk("t6_err_clean", {31'd0, err_unexp}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
